zx81_tape_encoder: RTL and testbench
====================================

Name: zx81_tape_encoder

Overview:
- Plays a loaded .p image as a real ZX81 cassette waveform, so the unpatched ROM LOAD routine decodes it through the tape_in bit of the keyboard port.
- Sits beside the tape buffer RAM and reads bytes through a 1-cycle-latency read port.
- Produces a single-bit tape_out level that feeds the port-FE bit 7 path.
- It is the transmit end of the tape interface: the rest of the core only consumes that bit.

Parameters:
- HALF_PULSE, 975: ce ticks per pulse half; 150 us at 6.5 MHz.
- BIT_GAP, 8450: ce ticks of silence after each bit; 1300 us.
- LEADER, 32500000: ce ticks of leading silence before the first byte; 5 s.
- AW, 14: buffer address width.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- ce, in, 1: timing enable, 6.5 MHz strobe; all timers advance only when ce=1.
- start, in, 1: one-cycle request to begin playback.
- abort, in, 1: stop playback immediately.
- length, in, AW: number of bytes to send; sampled on an accepted start.
- rd_addr, out, AW: buffer read address.
- rd_data, in, 8: buffer data, valid the cycle after rd_addr changes.
- tape_out, out, 1: tape signal; 1 = pulse high, 0 = silence or low.
- busy, out, 1: playback in progress.
- done, out, 1: one-cycle strobe when the last bit gap ends.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; tape_out=0, busy=0, done=0, rd_addr=0; all counters 0.
- FSM states: IDLE, LEADER, FETCH, LATCH, PULSE_HI, PULSE_LO, GAP, DONE.
- IDLE:
  - start=1 and length!=0: latch length, rd_addr<=0, busy<=1, go to LEADER.
  - start=1 and length=0: ignored; busy stays 0, done is not pulsed.
- LEADER: tape_out=0 for LEADER ce ticks, then FETCH.
- FETCH: rd_addr holds the byte index; next clk_sys cycle goes to LATCH, regardless of ce.
- LATCH:
  - shift register <= rd_data; bit counter <= 7.
  - pulse count <= 9 if bit7=1, else 4.
  - Then PULSE_HI.
- Bit order: MSB first.
- Pulse encoding:
  - A '1' bit is 9 pulses; a '0' bit is 4 pulses.
  - Each pulse is PULSE_HI (tape_out=1) for HALF_PULSE ticks, then PULSE_LO (tape_out=0) for HALF_PULSE ticks.
  - After the last pulse of a bit: GAP, tape_out=0 for BIT_GAP ticks.
- End of GAP:
  - More bits in the byte: shift left; reload pulse count from the new bit7; go to PULSE_HI.
  - Bit 0 finished and byte index < length-1: rd_addr+1, go to FETCH.
  - Otherwise: go to DONE.
- DONE: done=1 for exactly one clk_sys cycle, busy<=0, return to IDLE. tape_out stays 0.
- Timer: counts ce ticks from 0 to N-1. The transition occurs on the ce tick where the count equals N-1. ce=0 freezes the timer and the state; FETCH/LATCH are the only states exempt.
- start while busy=1: ignored. length changes while busy: no effect.
- abort=1: from any state except IDLE, go to IDLE next cycle with tape_out=0, busy=0, no done. abort has priority over start in the same cycle.
- rd_addr wraps only within AW bits. length=2^AW-1 is the maximum.
- Total ticks per byte = sum over its bits of (pulses*2*HALF_PULSE + BIT_GAP).

Optional Feature:
- Macro: ZX81_TAPE_NAME_EN.
- Defined:
  - Adds parameter NAME_BYTE (default 8'hA6, inverse "A"; bit7 set marks the last name character).
  - Adds a NAME state between LEADER and the first FETCH, which encodes NAME_BYTE exactly like a data byte.
  - rd_addr stays 0 during NAME.
  - The ROM's LOAD "" then accepts the file without a host-side name.
- Undefined: no NAME state; the stream starts directly with buffer byte 0, and the image must include its own name bytes.

Test Plan:
Benches use HALF_PULSE=2, BIT_GAP=5, LEADER=10, ce tied high.
1. Reset mid-pulse: reset_n low during PULSE_HI -> tape_out, busy and done are 0 immediately; a start after release plays normally.
2. length=1, rd_data=0x80 -> after 10 low ticks: 9 high pulses (each 2 high, 2 low), gap 5, then 7 bits of 4 pulses each. That is 37 rising edges total, with done one cycle after tick 10+36+28*4+40 = 198 (9 pulses in bit 7 = 36 ticks; 7 bits x 4 pulses x 4 ticks = 112; 8 gaps x 5 = 40).
3. length=3 with buffer {0x00,0xFF,0x01} -> rd_addr sequence 0,1,2; rising edges 32, 72, 37; one done pulse; busy low afterwards.
4. start with length=0 -> busy never rises, tape_out stays 0, no done.
5. abort asserted during the GAP of byte 0 -> state IDLE, tape_out=0, busy=0, no done; a new start still receives the full LEADER.
6. ce toggling 1-of-8 with length=1, data 0x00 -> same edge count (32) as ce=1, with durations stretched exactly 8x. A start while busy is ignored and does not restart rd_addr.

Source files
------------

// File: rtl/zx81_tape_encoder.sv
// zx81_tape_encoder: plays a tape buffer as ZX81 cassette pulses on tape_out.
// Define ZX81_TAPE_NAME_EN to prefix the stream with the built-in NAME_BYTE.
module zx81_tape_encoder #(
  parameter int HALF_PULSE = 975,
  parameter int BIT_GAP = 8450,
  parameter int LEADER = 32500000,
`ifdef ZX81_TAPE_NAME_EN
  parameter logic [7:0] NAME_BYTE = 8'hA6,
`endif
  parameter int AW = 14
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          tape_out,
  output logic          busy,
  output logic          done
);
  typedef enum logic [3:0] {
    S_IDLE,
    S_LEADER,
`ifdef ZX81_TAPE_NAME_EN
    S_NAME,
`endif
    S_FETCH,
    S_LATCH,
    S_PULSE_HI,
    S_PULSE_LO,
    S_GAP,
    S_DONE
  } state_t;
  state_t state;
  logic [31:0] cnt, lim;
  logic [AW-1:0] len;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] pulse_cnt;
  logic timed, tick;
`ifdef ZX81_TAPE_NAME_EN
  logic name_f;
`endif
  always_comb begin
    lim = state == S_LEADER ? 32'(LEADER - 1) : state == S_GAP ? 32'(BIT_GAP - 1) : 32'(HALF_PULSE - 1);
    timed = state inside {S_LEADER, S_PULSE_HI, S_PULSE_LO, S_GAP};
    tick = ce && timed && cnt == lim;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      len <= '0;
      sr <= '0;
      bit_cnt <= '0;
      pulse_cnt <= '0;
      rd_addr <= '0;
      tape_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef ZX81_TAPE_NAME_EN
      name_f <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        cnt <= '0;
        tape_out <= 1'b0;
        busy <= 1'b0;
`ifdef ZX81_TAPE_NAME_EN
        name_f <= 1'b0;
`endif
      end else begin
        if (ce && timed) cnt <= tick ? '0 : cnt + 32'd1;
        case (state)
          S_IDLE: if (start && length != '0) begin
            len <= length;
            rd_addr <= '0;
            busy <= 1'b1;
            state <= S_LEADER;
          end
`ifdef ZX81_TAPE_NAME_EN
          S_LEADER: if (tick) state <= S_NAME;
          S_NAME: begin
            sr <= NAME_BYTE;
            bit_cnt <= 3'd7;
            pulse_cnt <= NAME_BYTE[7] ? 4'd9 : 4'd4;
            name_f <= 1'b1;
            tape_out <= 1'b1;
            state <= S_PULSE_HI;
          end
`else
          S_LEADER: if (tick) state <= S_FETCH;
`endif
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            sr <= rd_data;
            bit_cnt <= 3'd7;
            pulse_cnt <= rd_data[7] ? 4'd9 : 4'd4;
            tape_out <= 1'b1;
            state <= S_PULSE_HI;
          end
          S_PULSE_HI: if (tick) begin
            tape_out <= 1'b0;
            state <= S_PULSE_LO;
          end
          S_PULSE_LO: if (tick) begin
            pulse_cnt <= pulse_cnt - 4'd1;
            tape_out <= pulse_cnt != 4'd1;
            state <= pulse_cnt == 4'd1 ? S_GAP : S_PULSE_HI;
          end
          S_GAP: if (tick) begin
            if (bit_cnt != 3'd0) begin
              sr <= {sr[6:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
              pulse_cnt <= sr[6] ? 4'd9 : 4'd4;
              tape_out <= 1'b1;
              state <= S_PULSE_HI;
            end
`ifdef ZX81_TAPE_NAME_EN
            else if (name_f) begin
              name_f <= 1'b0;
              state <= S_FETCH;
            end
`endif
            else if (rd_addr != len - AW'(1)) begin
              rd_addr <= rd_addr + AW'(1);
              state <= S_FETCH;
            end else begin
              done <= 1'b1;
              state <= S_DONE;
            end
          end
          S_DONE: if (ce) begin
            busy <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_zx81_tape_encoder.sv
// tb_zx81_tape_encoder: drives buffer images through the encoder and checks the
// tape waveform against a pulse-train model built from the bit pattern.
module tb_zx81_tape_encoder;
  localparam int HP = 2, BG = 5, LD = 10, AW = 14;
  logic clk_sys = 1'b0, reset_n = 1'b0, ce = 1'b1, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] length = '0;
  logic [AW-1:0] rd_addr;
  logic [7:0] rd_data;
  logic tape_out, busy, done;
  logic [7:0] mem [0:255];
  int vectors = 0, errors = 0, ce_div = 1, ce_cnt = 0;
  bit exp_t[$];
  bit cap_t[$], cap_b[$], cap_d[$];
  logic [AW-1:0] cap_a[$];

  zx81_tape_encoder #(.HALF_PULSE(HP), .BIT_GAP(BG), .LEADER(LD), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .start(start), .abort(abort),
    .length(length), .rd_addr(rd_addr), .rd_data(rd_data), .tape_out(tape_out),
    .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) rd_data <= mem[rd_addr[7:0]];
  always @(negedge clk_sys) begin
    ce_cnt = ce_cnt + 1;
    ce = (ce_cnt % ce_div) == 0;
  end

  // Expected per-cycle tape level: leader silence, then per byte two fetch
  // cycles followed by each bit's pulse train and trailing gap.
  function automatic void build(input int n);
    exp_t.delete();
    repeat (LD) exp_t.push_back(1'b0);
    for (int b = 0; b < n; b++) begin
      repeat (2) exp_t.push_back(1'b0);
      for (int i = 7; i >= 0; i--) begin
        for (int p = 0; p < (mem[b][i] ? 9 : 4); p++) begin
          repeat (HP) exp_t.push_back(1'b1);
          repeat (HP) exp_t.push_back(1'b0);
        end
        repeat (BG) exp_t.push_back(1'b0);
      end
    end
  endfunction

  function automatic int exp_edges(input int n);
    int e = 0;
    for (int b = 0; b < n; b++) e += $countones(mem[b]) * 9 + (8 - $countones(mem[b])) * 4;
    return e;
  endfunction

  task automatic kick(input logic [AW-1:0] l);
    @(negedge clk_sys);
    start = 1'b1;
    length = l;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
  endtask

  task automatic capture(input int n);
    cap_t.delete(); cap_b.delete(); cap_d.delete(); cap_a.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk_sys);
        #1;
      end
      cap_t.push_back(tape_out);
      cap_b.push_back(busy);
      cap_d.push_back(done);
      cap_a.push_back(rd_addr);
    end
  endtask

  task automatic test_playback(input string tag, input int n);
    int sz, e;
    build(n);
    sz = exp_t.size();
    kick(AW'(n));
    capture(sz + 2);
    for (int i = 0; i < sz; i++) begin
      vectors++;
      if (cap_t[i] !== exp_t[i] || cap_b[i] !== 1'b1 || cap_d[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: tape/busy/done=%b%b%b want %b10", tag, i, cap_t[i], cap_b[i], cap_d[i], exp_t[i]);
      end
    end
    vectors++;
    if (cap_d[sz] !== 1'b1 || cap_t[sz] !== 1'b0) begin
      errors++;
      $display("FAIL %s done_strobe: done=%b tape=%b at cycle %0d want done=1 tape=0", tag, cap_d[sz], cap_t[sz], sz);
    end
    vectors++;
    if (cap_b[sz+1] !== 1'b0 || cap_d[sz+1] !== 1'b0) begin
      errors++;
      $display("FAIL %s end_idle: busy=%b done=%b want 0 0", tag, cap_b[sz+1], cap_d[sz+1]);
    end
    e = 0;
    for (int i = 1; i < sz + 2; i++) if (cap_t[i] && !cap_t[i-1]) e++;
    vectors++;
    if (e != exp_edges(n)) begin
      errors++;
      $display("FAIL %s edges: got %0d want %0d", tag, e, exp_edges(n));
    end
    vectors++;
    if (cap_a[sz] !== AW'(n - 1)) begin
      errors++;
      $display("FAIL %s last_addr: got %0d want %0d", tag, cap_a[sz], n - 1);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (tape_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== '0) begin
      errors++;
      $display("FAIL reset_state: tape/busy/done=%b%b%b addr=%0d want 000 0", tape_out, busy, done, rd_addr);
    end
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    mem[0] = 8'h80;
    test_playback("single_80", 1);
  endtask

  task automatic test_multi;
    logic [AW-1:0] seq[$];
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h01;
    test_playback("multi", 3);
    seq.push_back(cap_a[0]);
    foreach (cap_a[i]) if (cap_a[i] !== seq[$]) seq.push_back(cap_a[i]);
    vectors++;
    if (seq.size() != 3 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 2) begin
      errors++;
      $display("FAIL multi addr_seq: got %0d values %p want 0,1,2", seq.size(), seq);
    end
  endtask

  task automatic test_zero_len;
    bit any_b = 0, any_t = 0, any_d = 0;
    kick('0);
    capture(40);
    foreach (cap_t[i]) begin
      any_b |= cap_b[i];
      any_t |= cap_t[i];
      any_d |= cap_d[i];
    end
    vectors++;
    if (any_b || any_t || any_d) begin
      errors++;
      $display("FAIL zero_len: busy/tape/done seen=%b%b%b want 000", any_b, any_t, any_d);
    end
  endtask

  task automatic test_abort;
    int idx;
    bit any_b = 0, any_d = 0;
    mem[0] = 8'($urandom); mem[1] = 8'($urandom);
    idx = LD + 2 + (mem[0][7] ? 9 : 4) * 2 * HP + 2;
    kick(AW'(2));
    repeat (idx) begin
      @(posedge clk_sys);
      #1;
    end
    @(negedge clk_sys);
    abort = 1'b1;
    @(posedge clk_sys);
    #1;
    abort = 1'b0;
    vectors++;
    if (tape_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: tape/busy/done=%b%b%b want 000", tape_out, busy, done);
    end
    capture(30);
    foreach (cap_b[i]) begin
      any_b |= cap_b[i];
      any_d |= cap_d[i];
    end
    vectors++;
    if (any_b || any_d) begin
      errors++;
      $display("FAIL abort_quiet: busy/done seen=%b%b want 00", any_b, any_d);
    end
    test_playback("after_abort", 2);
  endtask

  task automatic test_reset_mid;
    int w = 0;
    mem[0] = 8'($urandom);
    kick(AW'(1));
    while (!tape_out && w < 100) begin
      @(posedge clk_sys);
      #1;
      w++;
    end
    vectors++;
    if (tape_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid wait_pulse: tape=%b want 1 within 100 cycles", tape_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tape_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async: tape/busy/done=%b%b%b want 000", tape_out, busy, done);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    test_playback("after_reset", 1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 3; k++) begin
      int n = int'($urandom_range(1, 4));
      for (int b = 0; b < n; b++) mem[b] = 8'($urandom);
      test_playback($sformatf("random%0d", k), n);
    end
  endtask

  task automatic test_ce_div;
    int e = 0, run = 0, runs = 0, bad_run = 0, dones = 0, cyc = 0;
    bit prev = 0, rd_bad = 0, started = 0;
    ce_div = 8;
    mem[0] = 8'h00;
    kick(AW'(1));
    while (busy && cyc < 4000) begin
      @(posedge clk_sys);
      #1;
      cyc++;
      start = 1'b0;
      if (tape_out && !prev) e++;
      if (tape_out) run++;
      if (!tape_out && prev) begin
        runs++;
        if (runs > 1 && run != 8 * HP) bad_run++;
        run = 0;
      end
      if (done) dones++;
      if (rd_addr !== '0) rd_bad = 1;
      if (e == 5 && !started) begin
        started = 1;
        start = 1'b1;
        length = AW'(1);
      end
      prev = tape_out;
    end
    start = 1'b0;
    ce_div = 1;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ce_div timeout: busy=%b after %0d cycles want 0", busy, cyc);
    end
    vectors++;
    if (e != 32) begin
      errors++;
      $display("FAIL ce_div edges: got %0d want 32", e);
    end
    vectors++;
    if (bad_run != 0) begin
      errors++;
      $display("FAIL ce_div stretch: %0d high runs not %0d cycles, want 0", bad_run, 8 * HP);
    end
    vectors++;
    if (dones != 1 || rd_bad) begin
      errors++;
      $display("FAIL ce_div done/addr: dones=%0d addr_moved=%b want 1 0", dones, rd_bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset;
    test_single;
    test_multi;
    test_zero_len;
    test_abort;
    test_reset_mid;
    test_random;
    test_ce_div;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
